druaga_sprite_scanner: RTL
==========================

// Module: druaga_sprite_scanner
// PURPOSE
//  Video-side reader of sprite attribute RAM. This is the read port of the CPU-written sprite banks at
//  $1780-$17FF, $1F80-$1FFF and $2780-$27FF.
//  On each line-start pulse it walks all 64 entries, tests them against the next scanline, and
//  queues the visible ones in a small FIFO for the sprite line-buffer renderer.
//  Sits between the MEMS sprite port (SPRA_A/SPRA_D) and the sprite pixel fetcher in the video core.
// PARAMETERS
//  MAX_SPR   16  max visible sprites per line (FIFO depth); power of 2, 4..32
//  LAT        1  sprite RAM read latency in clocks; only 1 is supported
// PORTS
//  VCLKx4     in   1   video clock x4; the only clock
//  RESET_N    in   1   asynchronous, active-low reset
//  START      in   1   1-clk pulse: begin scanning for line LINE
//  LINE       in   9   scanline about to be drawn (PV+1, wraps 511->0)
//  SPRA_A     out  7   {entry[5:0], word}: sprite RAM read address
//  SPRA_D     in   24  {bank4, bank3, bank2} data; valid 1 clk after SPRA_A
//  OBJ_VALID  out  1   FIFO not empty
//  OBJ_READY  in   1   consumer pop; a pop occurs when OBJ_VALID & OBJ_READY
//  OBJ_D      out  33  {code[7:0], color[7:0], x[8:0], flipx, flipy, sizex, row[4:0]}
//  SCAN_BUSY  out  1   scan in progress
//  SCAN_DONE  out  1   1-clk pulse when the last entry has been evaluated
//  OVF        out  1   sticky per line: a visible sprite was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: SPRA_A=0, OBJ_VALID=0, OBJ_D=0, SCAN_BUSY=0, SCAN_DONE=0, OVF=0, FIFO empty, FSM in IDLE.
//  Entry layout:
//   - word0: [7:0] code, [15:8] Y[7:0], [16] flipx, [17] flipy, [18] sizex, [19] sizey.
//   - word1: [7:0] color, [15:8] X[7:0], [16] X[8], [17] Y[8], [18] disable.
//  FSM states: IDLE -> RD0 -> RD1 -> EVAL -> (RD1 | DONE) -> IDLE.
//   - Pipelined: while evaluating entry n, {n+1,0} is issued, so each entry costs 2 clocks.
//   - A scan takes 130 clocks from START to SCAN_DONE.
//   - RD0: drive {n,0}.
//   - RD1: latch word0, drive {n,1}.
//   - EVAL: latch word1, run the hit test, push on hit, drive {n+1,0}. After entry 63, go to DONE.
//   - DONE: pulse SCAN_DONE, drop SCAN_BUSY, go to IDLE.
//  Hit test:
//   - ydiff = (LINE - {Y8,Y[7:0]}) mod 512, computed as a 9-bit subtract.
//   - h = sizey ? 32 : 16.
//   - hit = !disable & (ydiff < h).
//   - row = ydiff[4:0], unflipped; the renderer applies flipy.
//  FIFO push order is scan order. OBJ_D is taken from the head, not registered; it is valid whenever
//  OBJ_VALID=1.
//  FIFO full (count==MAX_SPR) on a hit: drop the entry, set OVF. Scanning continues so SCAN_DONE
//  timing is unchanged.
//  A pop and a push in the same clock are both honoured; count is unchanged.
//  START in IDLE: flush the FIFO, clear OVF, n=0, assert SCAN_BUSY the next clock.
//  START mid-scan: abort, flush, clear OVF, restart at entry 0. No SCAN_DONE is emitted for the
//  aborted scan.
//  START and pop in the same clock: flush wins; the pop is ignored.
//  LINE is sampled at START and held internally; later changes do not affect the scan.
//  RESET_N asserted mid-scan: everything returns to reset values asynchronously.
// CONFIGURATION
//  DRUAGA_SPR_SCAN_REV_EN:
//   - defined: entries are scanned 63 down to 0, so lower-numbered sprites land later in the FIFO
//     and are drawn on top.
//   - undefined: entries are scanned 0 up to 63.
//   - Timing and all other behaviour are identical in both cases.
// STRUCTURE
//  Package druaga_video_pkg holds:
//   - SPR_ENTRIES=64, SPR_W0 / SPR_W1 field bit positions, OBJ_D field offsets;
//   - scan_state_t enum {IDLE, RD0, RD1, EVAL, DONE}.
//  One sub-module: druaga_obj_fifo. Synchronous FIFO, depth MAX_SPR, width 33, with flush,
//  push/pop, full/empty and count.
// TESTING
//  1. Entry 5: Y=100, sizey=0, X=0x123, code=0x42. LINE=107, all other entries disabled, START ->
//     one OBJ_D {0x42, .., x=0x123, row=7}; SCAN_DONE 130 clks after START.
//  2. Entry 0 with Y=0x1F8 (Y8=1), sizey=1, LINE=4 -> ydiff=12 -> hit with row=12 (wrap case).
//     LINE=24 -> no hit (ydiff=28, h=16 when sizey=0).
//  3. 20 entries all hit, OBJ_READY=0 -> 16 queued in ascending entry order, OVF=1.
//     Next START -> OVF=0 and the FIFO is empty.
//  4. OBJ_READY=1 throughout with 20 hits -> all 20 delivered, OVF=0 (simultaneous push and pop).
//  5. START again at clk 40 of a scan -> no SCAN_DONE for the first scan; the second completes
//     130 clks after the second START with only that scan's results.
//  6. RESET_N low mid-scan -> all outputs return to reset values immediately. Rerun test 3 with
//     DRUAGA_SPR_SCAN_REV_EN defined -> descending order.

Source files
------------

// File: rtl/druaga_video_pkg.sv
// Shared sprite-scan definitions: entry field positions, OBJ_D layout and scan FSM states.
package druaga_video_pkg;
   localparam int SPR_ENTRIES = 64;
   localparam int OBJ_W       = 33;

   localparam int SPR_W0_CODE  = 0;
   localparam int SPR_W0_Y     = 8;
   localparam int SPR_W0_FLIPX = 16;
   localparam int SPR_W0_FLIPY = 17;
   localparam int SPR_W0_SIZEX = 18;
   localparam int SPR_W0_SIZEY = 19;

   localparam int SPR_W1_COLOR = 0;
   localparam int SPR_W1_X     = 8;
   localparam int SPR_W1_X8    = 16;
   localparam int SPR_W1_Y8    = 17;
   localparam int SPR_W1_DIS   = 18;

   // OBJ_D = {code, color, x[8:0], flipx, flipy, sizex, row[4:0]}
   localparam int OBJ_ROW   = 0;
   localparam int OBJ_SIZEX = 5;
   localparam int OBJ_FLIPY = 6;
   localparam int OBJ_FLIPX = 7;
   localparam int OBJ_X     = 8;
   localparam int OBJ_COLOR = 17;
   localparam int OBJ_CODE  = 25;

   typedef enum logic [2:0] {IDLE, RD0, RD1, EVAL, DONE} scan_state_t;
endpackage

// File: rtl/druaga_obj_fifo.sv
// Synchronous FIFO with flush; head is presented combinationally (zero when empty).
// Push when full and pop when empty are ignored; flush overrides both.
module druaga_obj_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 33
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             head_dat,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == (AW+1)'(DEPTH));
   assign count    = cnt_q;
   assign head_dat = empty ? '0 : mem_q[rd_q];

   always_comb begin
      do_push = push & ~full & ~flush;
      do_pop  = pop & ~empty & ~flush;
      wr_d    = wr_q + AW'(do_push);
      rd_d    = rd_q + AW'(do_pop);
      cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_dat;
   end
endmodule

// File: rtl/druaga_sprite_scanner.sv
// Per-line sprite RAM walker: 64 entries at 2 clk each, SCAN_DONE 130 clk after START; hits queue in a FIFO.
// A hit with the FIFO full is dropped and sets OVF. DRUAGA_SPR_SCAN_REV_EN scans entries 63 down to 0.
module druaga_sprite_scanner
   import druaga_video_pkg::*;
#(
   parameter int MAX_SPR = 16,
   parameter int LAT     = 1
) (
   input  logic              VCLKx4,
   input  logic              RESET_N,
   input  logic              START,
   input  logic [8:0]        LINE,
   output logic [6:0]        SPRA_A,
   input  logic [23:0]       SPRA_D,
   output logic              OBJ_VALID,
   input  logic              OBJ_READY,
   output logic [OBJ_W-1:0]  OBJ_D,
   output logic              SCAN_BUSY,
   output logic              SCAN_DONE,
   output logic              OVF
);
`ifdef DRUAGA_SPR_SCAN_REV_EN
   localparam logic [5:0] FIRST_N = 6'(SPR_ENTRIES - 1);
   localparam logic [5:0] LAST_N  = 6'd0;
   localparam logic [5:0] N_STEP  = 6'h3F;
`else
   localparam logic [5:0] FIRST_N = 6'd0;
   localparam logic [5:0] LAST_N  = 6'(SPR_ENTRIES - 1);
   localparam logic [5:0] N_STEP  = 6'd1;
`endif
   // The word0/word1 pipeline assumes single-cycle RAM; any other latency never starts a scan.
   localparam logic LAT_OK = (LAT == 1);

   scan_state_t state_q, state_d;
   logic [5:0]  n_q, n_d, n_nxt;
   logic [8:0]  line_q, line_d;
   logic [19:0] word0_q, word0_d;
   logic        ovf_q, ovf_d;
   logic [8:0]  ydiff;
   logic        hit, push, flush;
   logic [OBJ_W-1:0] obj;
   logic        fifo_empty, fifo_full;
   logic [$clog2(MAX_SPR):0] unused_fifo_cnt;
   logic        unused_spra_d;

   assign unused_spra_d = ^SPRA_D[23:20];

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      line_d  = line_q;
      word0_d = word0_q;
      ovf_d   = ovf_q;
      push    = 1'b0;
      flush   = 1'b0;
      SPRA_A  = '0;
      n_nxt   = n_q + N_STEP;

      // word1 is on SPRA_D during EVAL; word0 was captured in RD1
      ydiff = line_q - {SPRA_D[SPR_W1_Y8], word0_q[SPR_W0_Y +: 8]};
      hit   = ~SPRA_D[SPR_W1_DIS] & (ydiff < (word0_q[SPR_W0_SIZEY] ? 9'd32 : 9'd16));

      obj = '0;
      obj[OBJ_ROW +: 5]   = ydiff[4:0];
      obj[OBJ_SIZEX]      = word0_q[SPR_W0_SIZEX];
      obj[OBJ_FLIPY]      = word0_q[SPR_W0_FLIPY];
      obj[OBJ_FLIPX]      = word0_q[SPR_W0_FLIPX];
      obj[OBJ_X +: 9]     = {SPRA_D[SPR_W1_X8], SPRA_D[SPR_W1_X +: 8]};
      obj[OBJ_COLOR +: 8] = SPRA_D[SPR_W1_COLOR +: 8];
      obj[OBJ_CODE +: 8]  = word0_q[SPR_W0_CODE +: 8];

      case (state_q)
         RD0: begin
            SPRA_A  = {n_q, 1'b0};
            state_d = RD1;
         end
         RD1: begin
            SPRA_A  = {n_q, 1'b1};
            word0_d = SPRA_D[19:0];
            state_d = EVAL;
         end
         EVAL: begin
            SPRA_A = {n_nxt, 1'b0};
            if (hit) begin
               if (fifo_full) ovf_d = 1'b1;
               else           push  = 1'b1;
            end
            if (n_q == LAST_N) begin
               state_d = DONE;
            end else begin
               n_d     = n_nxt;
               state_d = RD1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // START from any state restarts; the flush also swallows a same-cycle pop
      if (START && LAT_OK) begin
         flush   = 1'b1;
         push    = 1'b0;
         ovf_d   = 1'b0;
         n_d     = FIRST_N;
         line_d  = LINE;
         state_d = RD0;
      end
   end

   always_ff @(posedge VCLKx4 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         n_q     <= '0;
         line_q  <= '0;
         word0_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         line_q  <= line_d;
         word0_q <= word0_d;
         ovf_q   <= ovf_d;
      end
   end

   assign SCAN_BUSY = (state_q == RD0) || (state_q == RD1) || (state_q == EVAL);
   assign SCAN_DONE = (state_q == DONE);
   assign OVF       = ovf_q;
   assign OBJ_VALID = ~fifo_empty;

   druaga_obj_fifo #(
      .DEPTH (MAX_SPR),
      .W     (OBJ_W)
   ) u_fifo (
      .clk      (VCLKx4),
      .rst_n    (RESET_N),
      .flush    (flush),
      .push     (push),
      .push_dat (obj),
      .pop      (OBJ_READY),
      .head_dat (OBJ_D),
      .empty    (fifo_empty),
      .full     (fifo_full),
      .count    (unused_fifo_cnt)
   );
endmodule
